// File: rtl/alu_pkg.sv
// Shared constants, command encodings and operand-need decode for alu_core.
// The need decode follows ALU_MUL_EN so both the collector and datapath agree.
package alu_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int CMD_WIDTH_DEF = 4;
    localparam int ROR_WIDTH_DEF = 3;
    localparam int TIMEOUT       = 16;
    localparam int TMR_W         = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        A_ADD       = 4'd0,
        A_SUB       = 4'd1,
        A_ADD_CIN   = 4'd2,
        A_SUB_CIN   = 4'd3,
        A_INC_A     = 4'd4,
        A_DEC_A     = 4'd5,
        A_INC_B     = 4'd6,
        A_DEC_B     = 4'd7,
        A_CMP       = 4'd8,
        A_MUL_INC   = 4'd9,
        A_MUL_SHIFT = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        L_AND     = 4'd0,
        L_NAND    = 4'd1,
        L_OR      = 4'd2,
        L_NOR     = 4'd3,
        L_XOR     = 4'd4,
        L_XNOR    = 4'd5,
        L_NOT_A   = 4'd6,
        L_NOT_B   = 4'd7,
        L_SHR1_A  = 4'd8,
        L_SHL1_A  = 4'd9,
        L_SHR1_B  = 4'd10,
        L_SHL1_B  = 4'd11,
        L_ROL_A_B = 4'd12,
        L_ROR_A_B = 4'd13
    } logic_cmd_e;

    // Operands an op needs: bit0 = A, bit1 = B; 2'b00 marks an invalid command.
    function automatic logic [1:0] op_need(input logic mode, input logic [3:0] cmd);
        logic [1:0] n;
        n = 2'b00;
        if (mode) begin
            case (cmd)
                A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: n = 2'b11;
                A_INC_A, A_DEC_A:                          n = 2'b01;
                A_INC_B, A_DEC_B:                          n = 2'b10;
`ifdef ALU_MUL_EN
                A_MUL_INC, A_MUL_SHIFT:                    n = 2'b11;
`endif
                default:                                   n = 2'b00;
            endcase
        end else begin
            case (cmd)
                L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR: n = 2'b11;
                L_ROL_A_B, L_ROR_A_B:                      n = 2'b11;
                L_NOT_A, L_SHR1_A, L_SHL1_A:               n = 2'b01;
                L_NOT_B, L_SHR1_B, L_SHL1_B:               n = 2'b10;
                default:                                   n = 2'b00;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/alu_operand_collector.sv
// Gathers the two operands of an op that arrive in different cycles,
// latching command context and timing out after TIMEOUT enabled cycles.
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CMD_WIDTH = CMD_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic [1:0]           INP_VALID,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    input  logic                 CIN,
    output logic                 op_ready,
    output logic                 timeout,
    output logic                 op_mode,
    output logic [CMD_WIDTH-1:0] op_cmd,
    output logic                 op_cin,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic [1:0]           op_av
);

    logic                 busy_q;
    logic [1:0]           have_q;
    logic                 mode_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic                 cin_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [TMR_W-1:0]     cnt_q;
    logic [1:0]           need;
    logic                 start;
    logic                 fill;

    always_comb begin
        need     = op_need(MODE, CMD[3:0]);
        start    = 1'b0;
        fill     = 1'b0;
        op_ready = 1'b0;
        timeout  = 1'b0;
        op_mode  = MODE;
        op_cmd   = CMD;
        op_cin   = CIN;
        op_a     = OPA;
        op_b     = OPB;
        op_av    = INP_VALID;
        if (CE) begin
            if (!busy_q) begin
                if (need == 2'b11 && (INP_VALID == 2'b01 || INP_VALID == 2'b10))
                    start = 1'b1;
                else
                    op_ready = 1'b1;
            end else begin
                op_mode = mode_q;
                op_cmd  = cmd_q;
                op_cin  = cin_q;
                op_av   = 2'b11;
                if (have_q[0])
                    op_a = opnd_q;
                else
                    op_b = opnd_q;
                fill     = |(INP_VALID & ~have_q);
                op_ready = fill;
                timeout  = !fill && (cnt_q == TMR_W'(TIMEOUT - 1));
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_q <= 1'b0;
            have_q <= 2'b00;
            mode_q <= 1'b0;
            cmd_q  <= '0;
            cin_q  <= 1'b0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            have_q <= INP_VALID;
            mode_q <= MODE;
            cmd_q  <= CMD;
            cin_q  <= CIN;
            opnd_q <= INP_VALID[0] ? OPA : OPB;
            cnt_q  <= '0;
        end else if (fill || timeout) begin
            busy_q <= 1'b0;
            have_q <= 2'b00;
            cnt_q  <= '0;
        end else if (busy_q && CE) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_core.sv
// Registered arithmetic/logical ALU with split-operand collection.
// Define ALU_MUL_EN to build the two-cycle multiply commands.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CMD_WIDTH = CMD_WIDTH_DEF,
    parameter int ROR_WIDTH = ROR_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic [1:0]           INP_VALID,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    input  logic                 CIN,
    output logic [WIDTH+1:0]     RES,
    output logic                 COUT,
    output logic                 OFLOW,
    output logic                 G,
    output logic                 L,
    output logic                 E,
    output logic                 ERR
);

    localparam int RW = WIDTH + 2;

    logic                 op_ready;
    logic                 timeout;
    logic                 op_mode;
    logic [CMD_WIDTH-1:0] op_cmd;
    logic                 op_cin;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [1:0]           op_av;

    alu_operand_collector #(
        .WIDTH     (WIDTH),
        .CMD_WIDTH (CMD_WIDTH)
    ) u_coll (
        .CLK       (CLK),
        .RESET     (RESET),
        .CE        (CE),
        .MODE      (MODE),
        .CMD       (CMD),
        .INP_VALID (INP_VALID),
        .OPA       (OPA),
        .OPB       (OPB),
        .CIN       (CIN),
        .op_ready  (op_ready),
        .timeout   (timeout),
        .op_mode   (op_mode),
        .op_cmd    (op_cmd),
        .op_cin    (op_cin),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_av     (op_av)
    );

    logic [RW-1:0]        a_x;
    logic [RW-1:0]        b_x;
    logic [RW-1:0]        res_n;
    logic [WIDTH-1:0]     lres;
    logic [2*WIDTH-1:0]   aa;
    logic [2*WIDTH-1:0]   rol_t;
    logic [2*WIDTH-1:0]   ror_t;
    logic [ROR_WIDTH-1:0] rot_amt;
    logic [3:0]           c;
    logic [1:0]           need;
    logic                 is_rot;
    logic                 is_mul;
    logic                 bad;
    logic                 mul_go;
    logic                 wr;
    logic                 cout_n;
    logic                 ofl_n;
    logic                 g_n;
    logic                 l_n;
    logic                 e_n;
    logic                 err_n;

    always_comb begin
        a_x     = RW'(op_a);
        b_x     = RW'(op_b);
        c       = op_cmd[3:0];
        rot_amt = op_b[ROR_WIDTH-1:0];
        aa      = {op_a, op_a};
        rol_t   = aa << rot_amt;
        ror_t   = aa >> rot_amt;
        need    = op_need(op_mode, c);
        is_rot  = !op_mode && (c == L_ROL_A_B || c == L_ROR_A_B);
        bad     = (need == 2'b00) || (op_av == 2'b00)
               || ((need & ~op_av) != 2'b00)
               || (is_rot && ((op_b >> (ROR_WIDTH + 1)) != '0));
        res_n   = '0;
        lres    = '0;
        cout_n  = 1'b0;
        ofl_n   = 1'b0;
        g_n     = 1'b0;
        l_n     = 1'b0;
        e_n     = 1'b0;
        is_mul  = 1'b0;
        if (op_mode) begin
            unique case (c)
                A_ADD: begin
                    res_n  = a_x + b_x;
                    cout_n = res_n[WIDTH];
                end
                A_SUB: begin
                    res_n = a_x - b_x;
                    ofl_n = op_a < op_b;
                end
                A_ADD_CIN: begin
                    res_n  = a_x + b_x + RW'(op_cin);
                    cout_n = res_n[WIDTH];
                end
                A_SUB_CIN: begin
                    res_n = a_x - b_x - RW'(op_cin);
                    ofl_n = a_x < (b_x + RW'(op_cin));
                end
                A_INC_A: res_n = a_x + RW'(1);
                A_DEC_A: res_n = a_x - RW'(1);
                A_INC_B: res_n = b_x + RW'(1);
                A_DEC_B: res_n = b_x - RW'(1);
                A_CMP: begin
                    g_n = op_a > op_b;
                    l_n = op_a < op_b;
                    e_n = op_a == op_b;
                end
                A_MUL_INC, A_MUL_SHIFT: is_mul = 1'b1;
                default: ;
            endcase
        end else begin
            unique case (c)
                L_AND:     lres = op_a & op_b;
                L_NAND:    lres = ~(op_a & op_b);
                L_OR:      lres = op_a | op_b;
                L_NOR:     lres = ~(op_a | op_b);
                L_XOR:     lres = op_a ^ op_b;
                L_XNOR:    lres = ~(op_a ^ op_b);
                L_NOT_A:   lres = ~op_a;
                L_NOT_B:   lres = ~op_b;
                L_SHR1_A:  lres = op_a >> 1;
                L_SHL1_A:  lres = op_a << 1;
                L_SHR1_B:  lres = op_b >> 1;
                L_SHL1_B:  lres = op_b << 1;
                L_ROL_A_B: lres = rol_t[2*WIDTH-1:WIDTH];
                L_ROR_A_B: lres = ror_t[WIDTH-1:0];
                default: ;
            endcase
            res_n = RW'(lres);
        end
        mul_go = op_ready && is_mul && !bad;
        wr     = op_ready || timeout;
        err_n  = timeout || bad;
        if (err_n) begin
            res_n  = '0;
            cout_n = 1'b0;
            ofl_n  = 1'b0;
            g_n    = 1'b0;
            l_n    = 1'b0;
            e_n    = 1'b0;
        end
    end

`ifdef ALU_MUL_EN
    logic [RW-1:0] mul_n;
    logic [RW-1:0] mul_q;
    logic          mul_pend_q;

    always_comb begin
        mul_n = (c == A_MUL_INC) ? (a_x + RW'(1)) * (b_x + RW'(1))
                                 : (a_x << 1) * b_x;
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RES   <= '0;
            COUT  <= 1'b0;
            OFLOW <= 1'b0;
            G     <= 1'b0;
            L     <= 1'b0;
            E     <= 1'b0;
            ERR   <= 1'b0;
`ifdef ALU_MUL_EN
            mul_q      <= '0;
            mul_pend_q <= 1'b0;
`endif
        end else if (CE) begin
            if (wr && !mul_go) begin
                RES   <= res_n;
                COUT  <= cout_n;
                OFLOW <= ofl_n;
                G     <= g_n;
                L     <= l_n;
                E     <= e_n;
                ERR   <= err_n;
            end
`ifdef ALU_MUL_EN
            // A product retires one enabled cycle after its operands were taken.
            else if (mul_pend_q) begin
                RES   <= mul_q;
                COUT  <= 1'b0;
                OFLOW <= 1'b0;
                G     <= 1'b0;
                L     <= 1'b0;
                E     <= 1'b0;
                ERR   <= 1'b0;
            end
            mul_pend_q <= mul_go;
            if (mul_go)
                mul_q <= mul_n;
`endif
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core (default build, no multiplier).
module tb_alu_core;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CE;
    logic       MODE;
    logic [3:0] CMD;
    logic [1:0] INP_VALID;
    logic [7:0] OPA;
    logic [7:0] OPB;
    logic       CIN;
    logic [9:0] RES;
    logic       COUT;
    logic       OFLOW;
    logic       G;
    logic       L;
    logic       E;
    logic       ERR;

    int n_tests = 0;
    int n_fail  = 0;

    alu_core dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CE        (CE),
        .MODE      (MODE),
        .CMD       (CMD),
        .INP_VALID (INP_VALID),
        .OPA       (OPA),
        .OPB       (OPB),
        .CIN       (CIN),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .G         (G),
        .L         (L),
        .E         (E),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    // {RES, COUT, OFLOW, G, L, E, ERR}
    function automatic logic [15:0] outs();
        return {RES, COUT, OFLOW, G, L, E, ERR};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        MODE = m; CMD = c; INP_VALID = iv; OPA = a; OPB = b; CIN = ci;
    endtask

    task automatic test_reset();
        RESET = 1'b1; CE = 1'b0;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        step(); step();
        n_tests++;
        if (outs() !== 16'h0) begin
            n_fail++; $display("FAIL reset got %h exp %h", outs(), 16'h0);
        end
        RESET = 1'b0; CE = 1'b1;
    endtask

    task automatic test_arith();
        logic [15:0] exp;
        logic [13:0] lo;
        drive(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0); step();
        exp = {10'h100, 6'b100000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL add_ff_01 got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd1, 2'b11, 8'd5, 8'd9, 1'b0); step();
        lo = {RES[7:0], COUT, OFLOW, G, L, E, ERR}; n_tests++;
        if (lo !== {8'hFC, 6'b010000}) begin n_fail++; $display("FAIL sub_5_9 got %h exp %h", lo, {8'hFC, 6'b010000}); end
        drive(1'b1, 4'd1, 2'b11, 8'd9, 8'd5, 1'b0); step();
        exp = {10'd4, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL sub_9_5 got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd2, 2'b11, 8'h80, 8'h7F, 1'b1); step();
        exp = {10'h100, 6'b100000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL add_cin got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd3, 2'b11, 8'd5, 8'd5, 1'b1); step();
        lo = {RES[7:0], COUT, OFLOW, G, L, E, ERR}; n_tests++;
        if (lo !== {8'hFF, 6'b010000}) begin n_fail++; $display("FAIL sub_cin got %h exp %h", lo, {8'hFF, 6'b010000}); end
        drive(1'b1, 4'd4, 2'b01, 8'hFF, 8'h00, 1'b0); step();
        exp = {10'h100, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL inc_a got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd7, 2'b10, 8'h00, 8'h03, 1'b0); step();
        exp = {10'd2, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL dec_b got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd6, 2'b01, 8'h11, 8'h22, 1'b0); step();
        exp = {10'd0, 6'b000001}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL inc_b_missing got %h exp %h", outs(), exp); end
    endtask

    task automatic test_cmp();
        logic [15:0] exp;
        drive(1'b1, 4'd8, 2'b11, 8'd5, 8'd9, 1'b0); step();
        exp = {10'd0, 6'b000100}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL cmp_lt got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd8, 2'b11, 8'd9, 8'd9, 1'b0); step();
        exp = {10'd0, 6'b000010}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL cmp_eq got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd8, 2'b11, 8'd9, 8'd5, 1'b0); step();
        exp = {10'd0, 6'b001000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL cmp_gt got %h exp %h", outs(), exp); end
    endtask

    task automatic test_logic();
        logic [3:0]  cmds [6] = '{4'd0, 4'd5, 4'd3, 4'd7, 4'd9, 4'd10};
        logic [7:0]  as   [6] = '{8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h41, 8'h00};
        logic [7:0]  bs   [6] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h81};
        logic [1:0]  ivs  [6] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b10};
        logic [7:0]  want [6] = '{8'h30, 8'h33, 8'h03, 8'hC3, 8'h82, 8'h40};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, cmds[i], ivs[i], as[i], bs[i], 1'b0); step();
            n_tests++;
            if (outs() !== {2'b00, want[i], 6'b000000}) begin
                n_fail++;
                $display("FAIL logic_cmd%0d got %h exp %h", cmds[i], outs(), {2'b00, want[i], 6'b000000});
            end
        end
    endtask

    task automatic test_rotate();
        logic [15:0] exp;
        drive(1'b0, 4'd13, 2'b11, 8'h81, 8'h01, 1'b0); step();
        exp = {10'h0C0, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL ror_81_1 got %h exp %h", outs(), exp); end
        drive(1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0); step();
        exp = {10'h003, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL rol_81_1 got %h exp %h", outs(), exp); end
        drive(1'b0, 4'd13, 2'b11, 8'h81, 8'h10, 1'b0); step();
        exp = {10'h000, 6'b000001}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL ror_bad_amt got %h exp %h", outs(), exp); end
    endtask

    task automatic test_errors();
        logic [15:0] exp;
        logic        ms [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0]  cs [4] = '{4'd12, 4'd0, 4'd14, 4'd9};
        logic [1:0]  vs [4] = '{2'b11, 2'b00, 2'b11, 2'b11};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd4, 2'b11, 8'hAA, 8'h0F, 1'b0); step();
            drive(ms[i], cs[i], vs[i], 8'h12, 8'h34, 1'b0); step();
            exp = {10'd0, 6'b000001}; n_tests++;
            if (outs() !== exp) begin n_fail++; $display("FAIL err_case%0d got %h exp %h", i, outs(), exp); end
        end
    endtask

    task automatic test_split();
        logic [15:0] exp;
        drive(1'b0, 4'd4, 2'b11, 8'hF0, 8'h3C, 1'b0); step();
        drive(1'b1, 4'd0, 2'b01, 8'd3, 8'hEE, 1'b0); step();
        drive(1'b0, 4'd2, 2'b00, 8'h55, 8'h55, 1'b0); step(); step();
        exp = {10'h0CC, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL split_hold got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd1, 2'b10, 8'd9, 8'd2, 1'b0); step();
        exp = {10'd5, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL split_done got %h exp %h", outs(), exp); end
    endtask

    task automatic test_timeout();
        logic [15:0] exp;
        drive(1'b1, 4'd0, 2'b10, 8'h00, 8'd7, 1'b0); step();
        drive(1'b1, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (15) step();
        exp = {10'd5, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL timeout_early got %h exp %h", outs(), exp); end
        step();
        exp = {10'd0, 6'b000001}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL timeout_16 got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd0, 2'b11, 8'd1, 8'd1, 1'b0); step();
        exp = {10'd2, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL after_timeout got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd0, 2'b01, 8'd1, 8'h00, 1'b0); step();
        drive(1'b1, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (5) step();
        CE = 1'b0; repeat (4) step(); CE = 1'b1;
        repeat (10) step();
        n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL ce_freeze_early got %h exp %h", outs(), exp); end
        step();
        exp = {10'd0, 6'b000001}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL ce_freeze_16 got %h exp %h", outs(), exp); end
    endtask

    task automatic test_ce_hold();
        logic [15:0] exp;
        drive(1'b1, 4'd0, 2'b11, 8'd1, 8'd2, 1'b0); step();
        exp = {10'd3, 6'b000000};
        CE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(12 + i), 2'(i), 8'hFF, 8'hFF, 1'b1); step();
            n_tests++;
            if (outs() !== exp) begin n_fail++; $display("FAIL ce_hold%0d got %h exp %h", i, outs(), exp); end
        end
        CE = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        logic [15:0] exp;
        drive(1'b1, 4'd1, 2'b01, 8'd20, 8'h00, 1'b0); step();
        drive(1'b1, 4'd1, 2'b00, 8'h00, 8'h00, 1'b0); step(); step();
        RESET = 1'b1; #2;
        n_tests++;
        if (outs() !== 16'h0) begin n_fail++; $display("FAIL reset_async got %h exp %h", outs(), 16'h0); end
        #1 RESET = 1'b0;
        drive(1'b1, 4'd0, 2'b11, 8'd4, 8'd5, 1'b0); step();
        exp = {10'd9, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL after_reset got %h exp %h", outs(), exp); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        drive(1'b1, 4'd0, 2'b11, 8'd1, 8'd2, 1'b0); step();
        exp = {10'd3, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL b2b_add got %h exp %h", outs(), exp); end
        drive(1'b0, 4'd4, 2'b11, 8'hAA, 8'h0F, 1'b0); step();
        exp = {10'h0A5, 6'b000000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL b2b_xor got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd8, 2'b11, 8'd7, 8'd7, 1'b0); step();
        exp = {10'd0, 6'b000010}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL b2b_cmp got %h exp %h", outs(), exp); end
        drive(1'b1, 4'd2, 2'b11, 8'hFF, 8'hFF, 1'b1); step();
        exp = {10'h1FF, 6'b100000}; n_tests++;
        if (outs() !== exp) begin n_fail++; $display("FAIL b2b_add_cin got %h exp %h", outs(), exp); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_cmp();
        test_logic();
        test_rotate();
        test_errors();
        test_split();
        test_timeout();
        test_ce_hold();
        test_reset_mid_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
